// File: rtl/register_file_pkg.sv
// Shared sizing constants for the architectural register file and its lookup ports.
package register_file_pkg;
  localparam int ROB_BITS  = 4;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/register_file_lookup_port.sv
// One source-operand read port: x0 masking plus the same-cycle commit bypass.
module reg_lookup_port
  import register_file_pkg::*;
#(
  parameter int TAG_W = ROB_BITS
) (
  input  logic                 rdy_in,
  input  logic [REG_IDX_W-1:0] rs_id,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [31:0]          commit_value,
  input  logic [TAG_W-1:0]     commit_tag,
  input  logic [31:0]          stored_value,
  input  logic                 stored_busy,
  input  logic [TAG_W-1:0]     stored_tag,
  output logic                 rs_busy,
  output logic [31:0]          rs_value,
  output logic [TAG_W-1:0]     rs_tag
);

  // A committing write to the looked-up register resolves it this cycle unless
  // the register has since been renamed to a younger producer.
  always_comb begin
    rs_busy  = stored_busy;
    rs_value = stored_value;
    rs_tag   = stored_tag;
    if (rs_id == ZERO_REG) begin
      rs_busy  = 1'b0;
      rs_value = '0;
      rs_tag   = '0;
    end else if (rdy_in && (commit_rd == rs_id)) begin
      rs_value = commit_value;
      rs_busy  = stored_busy && (stored_tag != commit_tag);
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags, fed by the reorder buffer's
// commit, rename and flush streams, answering two source-operand lookups.
module register_file
  import register_file_pkg::*;
#(
  parameter int TAG_W = ROB_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [TAG_W-1:0]     issue_tag,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [31:0]          commit_value,
  input  logic [TAG_W-1:0]     commit_tag,
  input  logic                 flush_in,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  output logic                 rs1_busy,
  output logic [31:0]          rs1_value,
  output logic [TAG_W-1:0]     rs1_tag,
  output logic                 rs2_busy,
  output logic [31:0]          rs2_value,
  output logic [TAG_W-1:0]     rs2_tag,
  output logic [31:0]          commit_count
);

  logic [31:0]      value_q [REG_NUM];
  logic             busy_q  [REG_NUM];
  logic [TAG_W-1:0] tag_q   [REG_NUM];

  logic commit_en;
  logic rename_en;
  logic commit_clears;

  assign commit_en     = commit_rd != ZERO_REG;
  assign rename_en     = !flush_in && (issue_rd != ZERO_REG);
  assign commit_clears = busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag) &&
                         !(rename_en && (issue_rd == commit_rd));

  // Later assignments deliberately override earlier ones: flush clears every
  // busy bit after the commit, and a rename re-marks a register the commit freed.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
      commit_count <= '0;
    end else if (rdy_in) begin
      if (commit_en) begin
        value_q[commit_rd] <= commit_value;
        commit_count       <= commit_count + 32'd1;
        if (commit_clears) busy_q[commit_rd] <= 1'b0;
      end
      if (flush_in) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else if (rename_en) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_tag;
      end
    end
  end

  reg_lookup_port #(.TAG_W(TAG_W)) u_rs1 (
    .rdy_in       (rdy_in),
    .rs_id        (rs1_id),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .stored_value (value_q[rs1_id]),
    .stored_busy  (busy_q[rs1_id]),
    .stored_tag   (tag_q[rs1_id]),
    .rs_busy      (rs1_busy),
    .rs_value     (rs1_value),
    .rs_tag       (rs1_tag)
  );

  reg_lookup_port #(.TAG_W(TAG_W)) u_rs2 (
    .rdy_in       (rdy_in),
    .rs_id        (rs2_id),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .stored_value (value_q[rs2_id]),
    .stored_busy  (busy_q[rs2_id]),
    .stored_tag   (tag_q[rs2_id]),
    .rs_busy      (rs2_busy),
    .rs_value     (rs2_value),
    .rs_tag       (rs2_tag)
  );

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Architectural register file with rename tags. It sits directly downstream of the reorder buffer and consumes its commit (rd, value) stream, its issue-time tag assignments and its flush signal. It answers the issue stage's two source-operand lookups with the register value, or with the tag of the producing RoB entry. 32 x 32-bit registers; x0 is hardwired to zero.

Parameters:
ROB_BITS, `RoB_BITS (4), width of a RoB entry index / rename tag
REG_NUM, 32, number of architectural registers (index width fixed at 5)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global ready; low = freeze all state
issue_rd  input  5  destination register being renamed this cycle; 0 = no rename
issue_tag  input  ROB_BITS  RoB entry allocated to issue_rd
commit_rd  input  5  register written by the committing RoB head; 0 = no write
commit_value  input  32  value committed
commit_tag  input  ROB_BITS  RoB index of the committing entry
flush_in  input  1  RoB clear (mispredict or jalr redirect)
rs1_id  input  5  source-1 lookup index
rs2_id  input  5  source-2 lookup index
rs1_busy  output  1  1 = value pending; use rs1_tag
rs1_value  output  32  register value (valid when rs1_busy = 0)
rs1_tag  output  ROB_BITS  producer tag (valid when rs1_busy = 1)
rs2_busy, rs2_value, rs2_tag  output  1/32/ROB_BITS  same semantics as rs1
commit_count  output  32  number of register writes retired, for debug/perf

Behaviour:
- State per register: value[31:0], busy, tag[ROB_BITS-1:0]. Register 0 is never written. Its busy and tag stay 0.
- Reset (rst_in = 1, asynchronous): all values = 0, busy = 0, tags = 0, commit_count = 0. Outputs follow immediately: busy = 0, value = 0, tag = 0.
- rdy_in = 0: no state change. Lookup outputs remain combinationally valid.
- Commit (rising edge, rdy_in = 1, commit_rd != 0):
  - value[commit_rd] <= commit_value unconditionally.
  - busy[commit_rd] <= 0 only if busy = 1, tag[commit_rd] == commit_tag, and no same-cycle rename of the same register.
  - commit_count increments by 1 and wraps modulo 2^32.
- Rename (rising edge, rdy_in = 1, flush_in = 0, issue_rd != 0): busy[issue_rd] <= 1 and tag[issue_rd] <= issue_tag.
  - Rename wins over a same-cycle commit to the same register: busy stays 1, tag = issue_tag, and the value is still updated.
- Flush (rising edge, rdy_in = 1, flush_in = 1):
  - The same-cycle commit is still performed (the flushing instruction's rd is written).
  - All busy bits and tags are cleared.
  - Any same-cycle rename is discarded.
- Lookup (combinational, per port; rule below for rs1, rs2 identical):
  - rs1_id == 0: busy = 0, value = 0, tag = 0.
  - Commit bypass: if commit_rd == rs1_id != 0 and rdy_in, the value output is commit_value. Busy is 0 if the register is not busy or its tag == commit_tag; otherwise busy = 1 with the stored tag.
  - Otherwise, the stored value, busy and tag are output.
  - A same-cycle rename never affects lookups. An instruction reads its sources before its own rd is renamed, so addi x1,x1,1 sees the old producer of x1.
- Tags are unsigned ROB_BITS wide; no wrap handling beyond modulo arithmetic. Tag equality is exact.

Decomposition:
- Shared package/header (const.v): RoB_BITS, REG_NUM, REG_IDX_W = 5, and the ZERO_REG = 0 constant.
- One optional sub-module, reg_lookup_port: the combinational bypass/select logic, instantiated twice (rs1, rs2).
- Storage and the update arbitration stay in register_file.

Test Plan:
- Reset mid-run: write x5 = 0x1234, assert rst_in between edges -> rs1_id = 5 gives value 0, busy 0, and commit_count = 0 immediately.
- Rename then commit: issue_rd = 3, tag = 7; next cycle rs1_id = 3 -> busy 1, tag 7. Commit rd = 3, tag = 7, value = 0xDEADBEEF -> same-cycle lookup value 0xDEADBEEF with busy 0; after the edge, busy 0.
- Stale commit: x4 renamed to tag 2, then to tag 9; commit rd = 4, tag = 2, value = 0x55 -> value stored as 0x55, busy remains 1 with tag 9.
- Same-cycle rename and commit on x6 (commit tag = old tag 1, new tag 4) -> after the edge busy 1, tag 4, value = commit_value. A same-cycle lookup of x6 shows the pre-rename state (busy 0 via bypass).
- Flush with commit: x1, x2, x3 busy; flush_in = 1 with commit rd = 1, value = 0x80, and issue_rd = 2 -> after the edge all busy 0, x1 = 0x80, and x2 is not renamed.
- x0 protection and freeze: commit rd = 0, value = 0xFFFF -> x0 reads 0 and commit_count is unchanged. With rdy_in = 0, commit rd = 7 -> no change to x7 or commit_count.
